// File: rtl/ssm_pkg.sv
// Shared constants, record types and tile-select helper for the SSM tile feeder.
package ssm_pkg;
  localparam int DW              = 16;
  localparam int N_TILE          = 16;
  localparam int N_TOTAL         = 128;
  localparam int TILES_PER_GROUP = N_TOTAL / N_TILE;
  localparam int TILE_IDX_W      = $clog2(TILES_PER_GROUP);
  localparam int TILE_W          = N_TILE * DW;
  localparam int VEC_W           = N_TOTAL * DW;

  localparam logic [TILE_IDX_W-1:0] LAST_TILE = TILE_IDX_W'(TILES_PER_GROUP - 1);

  typedef struct packed {
    logic [DW-1:0]    dt;
    logic [DW-1:0]    dA;
    logic [DW-1:0]    x;
    logic [DW-1:0]    D;
    logic [VEC_W-1:0] B;
    logic [VEC_W-1:0] C;
    logic [VEC_W-1:0] hprev;
  } grp_t;

  typedef struct packed {
    logic [DW-1:0]     dt;
    logic [DW-1:0]     dA;
    logic [DW-1:0]     x;
    logic [DW-1:0]     D;
    logic [TILE_W-1:0] B;
    logic [TILE_W-1:0] C;
    logic [TILE_W-1:0] hprev;
  } tile_t;

  // Lanes [idx*N_TILE .. idx*N_TILE+N_TILE-1] of a group vector, lane 0 in the LSBs.
  function automatic logic [TILE_W-1:0] tile_slice(input logic [VEC_W-1:0]      v,
                                                   input logic [TILE_IDX_W-1:0] idx);
    return v[idx*TILE_W +: TILE_W];
  endfunction
endpackage

// File: rtl/ssm_tile_feeder_if.sv
// Group-in / tile-out bundle of the SSM tile feeder. Macro SSM_FEED_PERF_EN adds perf counters.
interface ssm_tile_feeder_if;
  import ssm_pkg::*;

  logic              flush_i;
  logic              grp_valid_i;
  logic              grp_ready_o;
  logic [DW-1:0]     dt_i;
  logic [DW-1:0]     dA_i;
  logic [DW-1:0]     x_i;
  logic [DW-1:0]     D_i;
  logic [VEC_W-1:0]  B_i;
  logic [VEC_W-1:0]  C_i;
  logic [VEC_W-1:0]  hprev_i;

  logic                  tile_valid_o;
  logic                  tile_ready_i;
  logic [DW-1:0]         dt_o;
  logic [DW-1:0]         dA_o;
  logic [DW-1:0]         x_o;
  logic [DW-1:0]         D_o;
  logic [TILE_W-1:0]     B_tile_o;
  logic [TILE_W-1:0]     C_tile_o;
  logic [TILE_W-1:0]     hprev_tile_o;
  logic [TILE_IDX_W-1:0] tile_idx_o;
  logic                  last_tile_o;

`ifdef SSM_FEED_PERF_EN
  logic [31:0] grp_cnt_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] starve_cnt_o;

  modport master (
    output flush_i, grp_valid_i, dt_i, dA_i, x_i, D_i, B_i, C_i, hprev_i, tile_ready_i,
    input  grp_ready_o, tile_valid_o, dt_o, dA_o, x_o, D_o, B_tile_o, C_tile_o,
           hprev_tile_o, tile_idx_o, last_tile_o, grp_cnt_o, stall_cnt_o, starve_cnt_o
  );
  modport slave (
    input  flush_i, grp_valid_i, dt_i, dA_i, x_i, D_i, B_i, C_i, hprev_i, tile_ready_i,
    output grp_ready_o, tile_valid_o, dt_o, dA_o, x_o, D_o, B_tile_o, C_tile_o,
           hprev_tile_o, tile_idx_o, last_tile_o, grp_cnt_o, stall_cnt_o, starve_cnt_o
  );
`else
  modport master (
    output flush_i, grp_valid_i, dt_i, dA_i, x_i, D_i, B_i, C_i, hprev_i, tile_ready_i,
    input  grp_ready_o, tile_valid_o, dt_o, dA_o, x_o, D_o, B_tile_o, C_tile_o,
           hprev_tile_o, tile_idx_o, last_tile_o
  );
  modport slave (
    input  flush_i, grp_valid_i, dt_i, dA_i, x_i, D_i, B_i, C_i, hprev_i, tile_ready_i,
    output grp_ready_o, tile_valid_o, dt_o, dA_o, x_o, D_o, B_tile_o, C_tile_o,
           hprev_tile_o, tile_idx_o, last_tile_o
  );
`endif
endinterface

// File: rtl/ssm_group_bank.sv
// One group storage bank: capture on write enable, FULL flag, tile-select read mux.
module ssm_group_bank
  import ssm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  grp_t                  grp_i,
  input  logic                  free_i,
  input  logic [TILE_IDX_W-1:0] tile_idx_i,
  output logic                  full_o,
  output tile_t                 tile_o
);
  grp_t grp_q;
  logic full_q;
  logic full_d;

  // Storage is zeroed only by rst; a flush leaves the stale contents in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      grp_q <= '0;
    end else if (wr_en_i) begin
      grp_q <= grp_i;
    end
  end

  always_comb begin
    full_d = full_q;
    if (free_i)  full_d = 1'b0;
    if (wr_en_i) full_d = 1'b1;
    if (clr_i)   full_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  assign full_o = full_q;

  always_comb begin
    tile_o.dt    = grp_q.dt;
    tile_o.dA    = grp_q.dA;
    tile_o.x     = grp_q.x;
    tile_o.D     = grp_q.D;
    tile_o.B     = tile_slice(grp_q.B, tile_idx_i);
    tile_o.C     = tile_slice(grp_q.C, tile_idx_i);
    tile_o.hprev = tile_slice(grp_q.hprev, tile_idx_i);
  end
endmodule

// File: rtl/ssm_tile_feeder.sv
// Ping-pong group buffer streaming each 128-lane group as 8 tiles of 16 lanes.
// Optional perf counters are enabled with macro SSM_FEED_PERF_EN.
module ssm_tile_feeder
  import ssm_pkg::*;
(
  input logic               clk,
  input logic               rst,
  ssm_tile_feeder_if.slave  bus
);
  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_e;

  rd_state_e             rd_state;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [TILE_IDX_W-1:0] tile_cnt_q, tile_cnt_d;
  logic [1:0]            full;
  logic [1:0]            wr_en;
  logic [1:0]            free;
  logic                  grp_ready;
  logic                  accept;
  logic                  xfer;
  logic                  last_xfer;
  grp_t                  grp_in;
  tile_t                 rd_tile [2];

  always_comb begin
    grp_in.dt    = bus.dt_i;
    grp_in.dA    = bus.dA_i;
    grp_in.x     = bus.x_i;
    grp_in.D     = bus.D_i;
    grp_in.B     = bus.B_i;
    grp_in.C     = bus.C_i;
    grp_in.hprev = bus.hprev_i;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ssm_group_bank u_bank (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (bus.flush_i),
      .wr_en_i    (wr_en[b]),
      .grp_i      (grp_in),
      .free_i     (free[b]),
      .tile_idx_i (tile_cnt_q),
      .full_o     (full[b]),
      .tile_o     (rd_tile[b])
    );
  end

  // Ready comes from bank flags only, so tile_ready_i never reaches grp_ready_o.
  always_comb begin
    rd_state   = full[rd_ptr_q] ? RD_STREAM : RD_IDLE;
    grp_ready  = ~full[wr_ptr_q];
    accept     = bus.grp_valid_i & grp_ready & ~bus.flush_i;
    xfer       = (rd_state == RD_STREAM) & bus.tile_ready_i & ~bus.flush_i;
    last_xfer  = xfer & (tile_cnt_q == LAST_TILE);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tile_cnt_d = tile_cnt_q;
    wr_en      = '0;
    free       = '0;
    if (accept) begin
      wr_en[wr_ptr_q] = 1'b1;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (last_xfer) begin
      free[rd_ptr_q] = 1'b1;
      rd_ptr_d       = ~rd_ptr_q;
      tile_cnt_d     = '0;
    end else if (xfer) begin
      tile_cnt_d = tile_cnt_q + 1'b1;
    end
    if (bus.flush_i) begin
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      tile_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      tile_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tile_cnt_q <= tile_cnt_d;
    end
  end

  assign bus.grp_ready_o  = grp_ready;
  assign bus.tile_valid_o = (rd_state == RD_STREAM);
  assign bus.dt_o         = rd_tile[rd_ptr_q].dt;
  assign bus.dA_o         = rd_tile[rd_ptr_q].dA;
  assign bus.x_o          = rd_tile[rd_ptr_q].x;
  assign bus.D_o          = rd_tile[rd_ptr_q].D;
  assign bus.B_tile_o     = rd_tile[rd_ptr_q].B;
  assign bus.C_tile_o     = rd_tile[rd_ptr_q].C;
  assign bus.hprev_tile_o = rd_tile[rd_ptr_q].hprev;
  assign bus.tile_idx_o   = tile_cnt_q;
  assign bus.last_tile_o  = (tile_cnt_q == LAST_TILE);

`ifdef SSM_FEED_PERF_EN
  logic [31:0] grp_cnt_q, grp_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] starve_cnt_q, starve_cnt_d;
  logic        seen_q, seen_d;

  // Starvation is only meaningful once the upstream has delivered something.
  always_comb begin
    grp_cnt_d    = grp_cnt_q + {31'd0, last_xfer};
    stall_cnt_d  = stall_cnt_q + {31'd0, (rd_state == RD_STREAM) & ~bus.tile_ready_i};
    starve_cnt_d = starve_cnt_q + {31'd0, (rd_state == RD_IDLE) & seen_q};
    seen_d       = seen_q | accept;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      grp_cnt_q    <= '0;
      stall_cnt_q  <= '0;
      starve_cnt_q <= '0;
      seen_q       <= 1'b0;
    end else begin
      grp_cnt_q    <= grp_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      seen_q       <= seen_d;
    end
  end

  assign bus.grp_cnt_o    = grp_cnt_q;
  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.starve_cnt_o = starve_cnt_q;
`endif
endmodule

// File: tb/tb_ssm_tile_feeder.sv
// Randomized bench for ssm_tile_feeder against a queue-based group/tile reference model.
module tb_ssm_tile_feeder;
  import ssm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ssm_tile_feeder_if bus ();
  ssm_tile_feeder dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: accepted groups in order, plus the tile position in the head group.
  grp_t m_q[$];
  int   m_tcnt      = 0;
  bit   expect_zero = 1'b0;
  bit   pat_mode    = 1'b0;
`ifdef SSM_FEED_PERF_EN
  int unsigned m_grp = 0, m_stall = 0, m_starve = 0;
  bit m_seen = 1'b0;
`endif

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic grp_t rand_grp(input logic [DW-1:0] dt);
    grp_t g;
    g.dt = dt;
    g.dA = 16'($urandom);
    g.x  = 16'($urandom);
    g.D  = 16'($urandom);
    for (int i = 0; i < VEC_W / 32; i++) begin
      g.B[i*32 +: 32]     = $urandom;
      g.C[i*32 +: 32]     = $urandom;
      g.hprev[i*32 +: 32] = $urandom;
    end
    return g;
  endfunction

  function automatic grp_t pat_grp(input logic [DW-1:0] dt);
    grp_t g;
    g = rand_grp(dt);
    for (int k = 0; k < N_TOTAL; k++) begin
      g.B[k*DW +: DW]     = 16'(k);
      g.C[k*DW +: DW]     = 16'(12'h100 + k);
      g.hprev[k*DW +: DW] = 16'(12'h200 + k);
    end
    return g;
  endfunction

  task automatic do_compare();
    bit   v;
    grp_t h;
    v = (m_q.size() > 0);
    check("tile_valid", 256'(bus.tile_valid_o), 256'(v));
    check("grp_ready", 256'(bus.grp_ready_o), 256'(m_q.size() < 2));
    check("tile_idx", 256'(bus.tile_idx_o), 256'(m_tcnt));
    check("last_tile", 256'(bus.last_tile_o), 256'(m_tcnt == TILES_PER_GROUP - 1));
    if (v) begin
      h = m_q[0];
      check("dt", 256'(bus.dt_o), 256'(h.dt));
      check("dA", 256'(bus.dA_o), 256'(h.dA));
      check("x", 256'(bus.x_o), 256'(h.x));
      check("D", 256'(bus.D_o), 256'(h.D));
      check("B_tile", 256'(bus.B_tile_o), 256'(h.B[m_tcnt*TILE_W +: TILE_W]));
      check("C_tile", 256'(bus.C_tile_o), 256'(h.C[m_tcnt*TILE_W +: TILE_W]));
      check("hprev_tile", 256'(bus.hprev_tile_o), 256'(h.hprev[m_tcnt*TILE_W +: TILE_W]));
      if (pat_mode && m_tcnt == 3) begin
        check("b_t3_l0", 256'(bus.B_tile_o[DW-1:0]), 256'd48);
        check("c_t3_l15", 256'(bus.C_tile_o[TILE_W-1 -: DW]), 256'h13f);
      end
    end
    if (expect_zero) begin
      check("zero_scalars", 256'({bus.dt_o, bus.dA_o, bus.x_o, bus.D_o}), 256'd0);
      check("zero_B", 256'(bus.B_tile_o), 256'd0);
      check("zero_C", 256'(bus.C_tile_o), 256'd0);
      check("zero_hprev", 256'(bus.hprev_tile_o), 256'd0);
    end
`ifdef SSM_FEED_PERF_EN
    check("grp_cnt", 256'(bus.grp_cnt_o), 256'(m_grp));
    check("stall_cnt", 256'(bus.stall_cnt_o), 256'(m_stall));
    check("starve_cnt", 256'(bus.starve_cnt_o), 256'(m_starve));
`endif
  endtask

  task automatic model_step(input bit gv, input grp_t g, input bit tr, input bit fl, input bit r);
    bit v, rdy, xfer, acc;
    v    = (m_q.size() > 0);
    rdy  = (m_q.size() < 2);
    xfer = v && tr;
    acc  = gv && rdy;
    expect_zero = r;
    if (r || fl) begin
      m_q.delete();
      m_tcnt = 0;
`ifdef SSM_FEED_PERF_EN
      m_grp = 0; m_stall = 0; m_starve = 0; m_seen = 1'b0;
`endif
      return;
    end
`ifdef SSM_FEED_PERF_EN
    if (xfer && m_tcnt == TILES_PER_GROUP - 1) m_grp++;
    if (v && !tr) m_stall++;
    if (!v && m_seen) m_starve++;
    if (acc) m_seen = 1'b1;
`endif
    if (xfer) begin
      if (m_tcnt == TILES_PER_GROUP - 1) begin
        void'(m_q.pop_front());
        m_tcnt = 0;
      end else begin
        m_tcnt++;
      end
    end
    if (acc) m_q.push_back(g);
  endtask

  task automatic cycle(input bit gv, input grp_t g, input bit tr, input bit fl, input bit r,
                       input bit cmp);
    @(posedge clk);
    #1;
    rst              = r;
    bus.flush_i      = fl;
    bus.grp_valid_i  = gv;
    bus.dt_i         = g.dt;
    bus.dA_i         = g.dA;
    bus.x_i          = g.x;
    bus.D_i          = g.D;
    bus.B_i          = g.B;
    bus.C_i          = g.C;
    bus.hprev_i      = g.hprev;
    bus.tile_ready_i = tr;
    @(negedge clk);
    if (cmp) do_compare();
    model_step(gv, g, tr, fl, r);
  endtask

  task automatic idle(input int n, input bit tr);
    for (int i = 0; i < n; i++) cycle(1'b0, rand_grp(16'($urandom)), tr, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    grp_t g1, g2, g3;
    bit   taken;
    int   stall_left;
    bus.flush_i = 1'b0; bus.grp_valid_i = 1'b0; bus.tile_ready_i = 1'b0;
    bus.dt_i = '0; bus.dA_i = '0; bus.x_i = '0; bus.D_i = '0;
    bus.B_i = '0; bus.C_i = '0; bus.hprev_i = '0;

    // Reset, then confirm the reset state.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Single patterned group, continuous ready.
    pat_mode = 1'b1;
    cycle(1'b1, pat_grp(16'h3C00), 1'b1, 1'b0, 1'b0, 1'b1);
    idle(11, 1'b1);
    pat_mode = 1'b0;

    // Two back-to-back groups and a third that must wait for a free bank.
    g1 = rand_grp(16'h3C00); g2 = rand_grp(16'h4000); g3 = rand_grp(16'h4200);
    cycle(1'b1, g1, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, g2, 1'b1, 1'b0, 1'b0, 1'b1);
    taken = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bit off;
      off = !taken;
      if (off && m_q.size() < 2) taken = 1'b1;
      cycle(off, g3, 1'b1, 1'b0, 1'b0, 1'b1);
    end

    // Downstream stall of 3 cycles at tile 2.
    cycle(1'b1, rand_grp(16'h1111), 1'b1, 1'b0, 1'b0, 1'b1);
    stall_left = 3;
    for (int i = 0; i < 16; i++) begin
      bit tr;
      tr = !(m_q.size() > 0 && m_tcnt == 2 && stall_left > 0);
      if (!tr) stall_left--;
      cycle(1'b0, rand_grp(16'($urandom)), tr, 1'b0, 1'b0, 1'b1);
    end

    // Flush at tile 5 of group 1 while group 2 waits; a group offered in that cycle is dropped.
    cycle(1'b1, rand_grp(16'h2222), 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, rand_grp(16'h3333), 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if (m_q.size() == 2 && m_tcnt == 5) begin
        cycle(1'b1, rand_grp(16'h4444), 1'b1, 1'b1, 1'b0, 1'b1);
        break;
      end
      cycle(1'b0, rand_grp(16'($urandom)), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    idle(1, 1'b1);
    cycle(1'b1, rand_grp(16'h5555), 1'b1, 1'b0, 1'b0, 1'b1);
    idle(10, 1'b1);

    // Reset mid-stream, then a fresh group.
    cycle(1'b1, rand_grp(16'h6666), 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, rand_grp(16'h7777), 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);
    cycle(1'b0, rand_grp(16'h0), 1'b1, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b1);
    cycle(1'b1, rand_grp(16'h8888), 1'b1, 1'b0, 1'b0, 1'b1);
    idle(10, 1'b1);

`ifdef SSM_FEED_PERF_EN
    // Three groups with four stall cycles, starting from cleared counters.
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    stall_left = 4;
    for (int i = 0; i < 40; i++) begin
      bit gv, tr;
      gv = (i < 3);
      tr = !(i >= 6 && stall_left > 0);
      if (!tr && m_q.size() > 0) stall_left--;
      else tr = 1'b1;
      cycle(gv, rand_grp(16'($urandom)), tr, 1'b0, 1'b0, 1'b1);
    end
    check("perf_grp3", 256'(bus.grp_cnt_o), 256'd3);
    check("perf_stall4", 256'(bus.stall_cnt_o), 256'd4);
`endif

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      bit gv, tr, fl, r;
      gv = ($urandom_range(0, 2) != 0);
      tr = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 99) == 0);
      r  = ($urandom_range(0, 299) == 0);
      cycle(gv, rand_grp(16'($urandom)), tr, fl, r, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
